// File: rtl/ascon_pack.sv
// Shared word and block types for the Ascon datapath, plus a small helper
// that builds a 64-bit block from its two 32-bit halves.
package ascon_pack;

    typedef logic [31:0]  u32_t;
    typedef logic [63:0]  u64_t;
    typedef logic [127:0] u128_t;

    // The first word of a pair occupies the upper half of the block.
    function automatic u64_t pack_pair(input u32_t hi_word, input u32_t lo_word);
        return {hi_word, lo_word};
    endfunction

endpackage

// File: rtl/word_packer.sv
// Collects host words in pairs and emits one assembled 64-bit block per commit.
// A lone first word flagged as last is committed on its own, zero-padded.
module word_packer
    import ascon_pack::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_wr_en,
    input  logic [31:0] i_wr_data,
    input  logic i_wr_last,
    output logic o_commit,
    output logic [63:0] o_block
);

    logic r_half;
    u32_t r_hold;

    // Commit on a second word, or on a first word that ends the message.
    always_comb begin
        o_commit = i_wr_en && (r_half || i_wr_last);
        o_block  = r_half ? pack_pair(r_hold, i_wr_data)
                          : pack_pair(i_wr_data, 32'h0);
    end

    // Track a pending first half; flush discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half <= 1'b0;
            r_hold <= '0;
        end else if (i_flush) begin
            r_half <= 1'b0;
            r_hold <= '0;
        end else if (i_wr_en) begin
            if (r_half || i_wr_last) begin
                r_half <= 1'b0;
            end else begin
                r_half <= 1'b1;
                r_hold <= i_wr_data;
            end
        end
    end

endmodule

// File: rtl/ascon_in_fifo.sv
// Input FIFO feeding one Ascon core stream (AD or PT). Host words are packed
// into 64-bit blocks and stored in a circular buffer; the head block is
// presented first-word-fall-through to the core.
module ascon_in_fifo
    import ascon_pack::*;
#(
    parameter int Depth     = 8,
    parameter int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [31:0]          wr_data_i,
    input  logic                 wr_last_i,
    input  logic                 pop_i,
    input  logic                 flush_i,
    output logic [63:0]          data_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic [AddrWidth:0]   count_o,
    output logic                 err_o
);

    localparam logic [AddrWidth:0]   LP_DEPTH   = (AddrWidth + 1)'(Depth);
    localparam logic [AddrWidth-1:0] LP_PTR_ONE = AddrWidth'(1);
    localparam logic [AddrWidth:0]   LP_CNT_ONE = (AddrWidth + 1)'(1);

    logic [AddrWidth-1:0] r_rd_ptr;
    logic [AddrWidth-1:0] r_wr_ptr;
    logic [AddrWidth:0]   r_count;
    logic [AddrWidth:0]   w_count_next;
    logic                 r_err;
    u64_t                 r_mem [Depth];

    logic w_wr_en;
    logic w_pop_ok;
    logic w_pop_empty;
    logic w_commit;
    u64_t w_block;

    // Handshake qualifiers; flush overrides both write and pop.
    always_comb begin
        empty_o     = (r_count == '0);
        full_o      = (r_count == LP_DEPTH);
        wr_ready_o  = !full_o;
        w_wr_en     = wr_valid_i && wr_ready_o && !flush_i;
        w_pop_ok    = pop_i && !empty_o && !flush_i;
        w_pop_empty = pop_i && empty_o && !flush_i;
        count_o     = r_count;
        err_o       = r_err;
        data_o      = empty_o ? 64'h0 : r_mem[r_rd_ptr];
    end

    word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (flush_i),
        .i_wr_en   (w_wr_en),
        .i_wr_data (wr_data_i),
        .i_wr_last (wr_last_i),
        .o_commit  (w_commit),
        .o_block   (w_block)
    );

    // Occupancy update: a commit and a pop in the same cycle cancel out.
    always_comb begin
        w_count_next = r_count;
        case ({w_commit, w_pop_ok})
            2'b10:   w_count_next = r_count + LP_CNT_ONE;
            2'b01:   w_count_next = r_count - LP_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Pointers, count and sticky underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_commit) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            if (w_pop_empty) begin
                r_err <= 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // Block storage; contents are never reset, only overwritten on commit.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_wr_ptr] <= w_block;
        end
    end

endmodule

// File: tb/tb_ascon_in_fifo.sv
// Self-checking bench for ascon_in_fifo: directed steps from the test plan,
// then a randomized phase, all compared against a queue-based reference model.
module tb_ascon_in_fifo;
    import ascon_pack::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [31:0] wr_data_i;
    logic        wr_last_i;
    logic        pop_i;
    logic        flush_i;
    logic [63:0] data_o;
    logic        empty_o;
    logic        full_o;
    logic [3:0]  count_o;
    logic        err_o;

    always #5 clk = ~clk;

    ascon_in_fifo #(.Depth(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .wr_data_i  (wr_data_i),
        .wr_last_i  (wr_last_i),
        .pop_i      (pop_i),
        .flush_i    (flush_i),
        .data_o     (data_o),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .count_o    (count_o),
        .err_o      (err_o)
    );

    // Reference model: a queue of committed blocks plus a pending half word.
    u64_t        mq[$];
    logic        m_half;
    logic [31:0] m_hold;
    logic        m_err;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : 64'h0;
        chk({tag, ".count"}, 64'(count_o), 64'(mq.size()));
        chk({tag, ".empty"}, 64'(empty_o), 64'(mq.size() == 0));
        chk({tag, ".full"},  64'(full_o),  64'(mq.size() == DEPTH));
        chk({tag, ".ready"}, 64'(wr_ready_o), 64'(mq.size() < DEPTH));
        chk({tag, ".err"},   64'(err_o), 64'(m_err));
        chk({tag, ".data"},  data_o, exp_data);
    endtask

    task automatic model_clear();
        mq.delete();
        m_half = 1'b0;
        m_hold = '0;
        m_err  = 1'b0;
    endtask

    // One clock cycle of stimulus; entered and left on a falling edge.
    task automatic step(input string tag, input logic v, input logic [31:0] d,
                        input logic l, input logic p, input logic f);
        logic acc;
        wr_valid_i = v;
        wr_data_i  = d;
        wr_last_i  = l;
        pop_i      = p;
        flush_i    = f;
        #1;
        chk({tag, ".ready_pre"}, 64'(wr_ready_o), 64'(mq.size() < DEPTH));
        acc = v && (mq.size() < DEPTH) && !f;
        @(posedge clk);
        if (f) begin
            model_clear();
        end else begin
            if (p) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else m_err = 1'b1;
            end
            if (acc) begin
                if (m_half) begin
                    mq.push_back({m_hold, d});
                    m_half = 1'b0;
                end else if (l) begin
                    mq.push_back({d, 32'h0});
                end else begin
                    m_half = 1'b1;
                    m_hold = d;
                end
            end
        end
        @(negedge clk);
        wr_valid_i = 1'b0;
        wr_last_i  = 1'b0;
        pop_i      = 1'b0;
        flush_i    = 1'b0;
        $display("step %s v=%0b d=%h l=%0b p=%0b f=%0b -> count=%0d data=%h err=%0b",
                 tag, v, d, l, p, f, count_o, data_o, err_o);
        check_all(tag);
    endtask

    initial begin
        rst_n      = 1'b0;
        wr_valid_i = 1'b0;
        wr_data_i  = '0;
        wr_last_i  = 1'b0;
        pop_i      = 1'b0;
        flush_i    = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("reset");

        // Basic pair, then pop back to empty.
        step("pair_w0", 1, 32'h01234567, 0, 0, 0);
        step("pair_w1", 1, 32'h89ABCDEF, 0, 0, 0);
        chk("pair.data_const", data_o, 64'h0123456789ABCDEF);
        step("pair_pop", 0, 0, 0, 1, 0);

        // Lone first word with last set.
        step("last_w0", 1, 32'hDEADBEEF, 1, 0, 0);
        chk("last.data_const", data_o, 64'hDEADBEEF00000000);
        step("last_pop", 0, 0, 0, 1, 0);

        // Fill to Depth, reject extra words, then wrap and drain.
        for (int i = 0; i < 2 * DEPTH; i++)
            step("fill", 1, 32'hA0000000 + 32'(i), 0, 0, 0);
        chk("fill.full_const", 64'(full_o), 64'h1);
        step("fill_reject", 1, 32'hBADBAD00, 0, 0, 0);
        step("fill_reject_last", 1, 32'hBADBAD01, 1, 0, 0);
        step("fill_pop1", 0, 0, 0, 1, 0);
        step("wrap_w0", 1, 32'hC0000000, 0, 0, 0);
        step("wrap_w1", 1, 32'hC0000001, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            step("drain", 0, 0, 0, 1, 0);

        // Commit and pop in the same cycle with three blocks stored.
        for (int i = 0; i < 6; i++)
            step("cp_fill", 1, 32'hD0000000 + 32'(i), 0, 0, 0);
        step("cp_half", 1, 32'hE0000000, 0, 0, 0);
        step("cp_both", 1, 32'hE0000001, 0, 1, 0);
        chk("cp.count_const", 64'(count_o), 64'd3);

        // Underflow flag is sticky until flush.
        step("flush0", 0, 0, 0, 0, 1);
        step("uf_pop", 0, 0, 0, 1, 0);
        step("uf_hold", 0, 0, 0, 0, 0);
        step("uf_flush", 0, 0, 0, 0, 1);

        // Flush drops a pending half and the word offered with it.
        step("fl_half", 1, 32'h55555555, 0, 0, 0);
        step("fl_word", 1, 32'h66666666, 0, 0, 1);
        step("fl_w0", 1, 32'h11111111, 0, 0, 0);
        step("fl_w1", 1, 32'h22222222, 0, 0, 0);
        chk("fl.data_const", data_o, 64'h1111111122222222);
        step("fl_pop", 0, 0, 0, 1, 0);

        // Reset in the middle of a message discards the half word.
        step("rst_half", 1, 32'h77777777, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("rst_mid");
        step("rst_w0", 1, 32'h88888888, 0, 0, 0);
        step("rst_w1", 1, 32'h99999999, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 9) < 6),
                 $urandom(),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 49) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ascon_in_fifo.md
# ascon_in_fifo

Input-side FIFO that feeds the Ascon core's AD and PT ports, one instance per stream. It accepts 32-bit words from the host register interface, packs word pairs into 64-bit blocks, and stores them. It serves the core through the core's pop/empty/flush handshake. Output is first-word-fall-through: the head block is always presented on `data_o`.

## Interface
Parameters:
- `Depth`, 8: number of 64-bit entries; must be a power of two, ≥ 2.
- `AddrWidth`, `$clog2(Depth)`: derived; not to be overridden.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `wr_valid_i`, in, 1: host word valid.
- `wr_ready_o`, out, 1: host word accepted when high together with `wr_valid_i`.
- `wr_data_i`, in, 32: host word.
- `wr_last_i`, in, 1: marks the final word of a message.
- `pop_i`, in, 1: core consumes the head block (connects to core `*_pop_o`).
- `flush_i`, in, 1: core clears the FIFO (connects to core `*_flush_o`).
- `data_o`, out, 64 (`u64_t`): head block (connects to core `*_i`).
- `empty_o`, out, 1: no committed block.
- `full_o`, out, 1: `Depth` committed blocks.
- `count_o`, out, `AddrWidth+1`: number of committed blocks.
- `err_o`, out, 1: sticky underflow flag.

## Operation
- Host write occurs on a cycle with `wr_valid_i && wr_ready_o`. `wr_ready_o = !full_o`; it is a combinational function of registered state.
- Packing:
  - The first word of a pair goes to `[63:32]`; the second word goes to `[31:0]`.
  - A holding register plus a `half_q` flag store a pending first word.
- Commit rules:
  - A second word commits the block.
  - A first word with `wr_last_i=1` commits the block immediately, with `[31:0]=0`.
  - `wr_last_i` on a second word commits normally.
  - After any commit, `half_q=0`.
- Storage: circular buffer with `rd_ptr`/`wr_ptr` of `AddrWidth` bits; both wrap modulo `Depth`. `count_q` is `AddrWidth+1` bits.
- Pop:
  - `pop_i` with `empty_o=0` advances `rd_ptr`.
  - `pop_i` with `empty_o=1` does not change pointers or count, and sets `err_o`.
- Simultaneous commit and pop: both pointers advance; `count_o` is unchanged.
- Flush: `flush_i` has priority over write and pop in the same cycle. It clears pointers, `count_q`, `half_q`, the holding register and `err_o`. A host word presented that cycle is dropped, and `wr_ready_o` still reads as before.
- `data_o` is `mem[rd_ptr]` when not empty, and `64'h0` when empty.
- Storage memory is not reset; every other register is.

## Timing
- Reset values:
  - `wr_ready_o=1`, `empty_o=1`, `full_o=0`.
  - `count_o=0`, `err_o=0`, `data_o=0`.
- Latency: a block committed at edge N is visible on `data_o`, `empty_o` and `count_o` after edge N. Write-to-read latency is 1 cycle.
- Pop: the next head block appears on `data_o` the cycle after the pop edge.
- Full: `full_o` and `!wr_ready_o` in the cycle after the `Depth`-th commit. No host word is accepted, including first halves, until a pop or flush.
- Wrap-around: after a pointer passes `Depth-1`, it returns to 0 with no bubble.
- Reset mid-message: any pending half-word is discarded.
- Flush with a half-word pending: the half-word is discarded.
- The first host word after a flush is treated as a first half.

## Structure
- Add `u32_t` to `ascon_pack`, next to the existing `u64_t`/`u128_t`.
- One sub-module, `word_packer`: holding register, `half_q`, commit strobe and assembled `u64_t`.
- Pointer, count and memory logic live in `ascon_in_fifo`.

## Test plan
- Reset, then write `32'h01234567`, `32'h89ABCDEF`:
  - one cycle after the second write, `empty_o=0`, `count_o=1`, `data_o=64'h0123456789ABCDEF`;
  - a pop then gives `empty_o=1`.
- Write `32'hDEADBEEF` with `wr_last_i=1` → `data_o=64'hDEADBEEF00000000`, `count_o=1`.
- Fill 8 blocks (`Depth=8`) → `full_o=1`, `wr_ready_o=0`, and a 17th word is not accepted. One pop, then a new pair → pointers wrap, and 8 pops return all blocks in order.
- With `count_o=3`, commit and pop in the same cycle → `count_o=3`, and the head advances by one block.
- Pop while empty → `err_o=1`, held. A subsequent `flush_i` → `err_o=0`.
- Write one first-half word, then `flush_i` in the same cycle as a second word → `count_o=0`, `empty_o=1`. The next pair `32'h11111111`, `32'h22222222` yields `64'h1111111122222222`.
